// File: rtl/her_dispatch_buffer.sv
// HER dispatch buffer: a fall-through FIFO between the packet source and the scheduler.
// It limits the number of in-flight handlers and signals end-of-stream once all work has drained.
module her_dispatch_buffer #(
    parameter int DEPTH        = 8,
    parameter int MAX_INFLIGHT = 32,
    parameter int DESCR_W      = 64,
    parameter int OCC_W        = $clog2(DEPTH + 1),
    parameter int INF_W        = $clog2(MAX_INFLIGHT + 1)
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               her_valid_i,
    output logic               her_ready_o,
    input  logic [DESCR_W-1:0] her_descr_i,

    output logic               her_valid_o,
    input  logic               her_ready_i,
    output logic [DESCR_W-1:0] her_descr_o,

    input  logic               feedback_valid_i,
    output logic               feedback_ready_o,

    input  logic               eos_i,
    output logic               eos_o,

    output logic [OCC_W-1:0]   occupancy_o,
    output logic [INF_W-1:0]   inflight_o,
    output logic               fb_underflow_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
    localparam logic [INF_W-1:0] INF_MAX  = INF_W'(MAX_INFLIGHT);
    localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
    localparam logic [INF_W-1:0] INF_ONE  = INF_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [DESCR_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [INF_W-1:0] inflight_q, inflight_d;
    logic             eos_seen_q, eos_seen_d;
    logic             eos_q, eos_d;
    logic             underflow_q, underflow_d;

    logic push;
    logic pop;
    logic fb;

    // Both handshakes depend only on registered state, so neither side sees a combinational path.
    assign her_ready_o = (occ_q != OCC_FULL);
    assign her_valid_o = (occ_q != '0) && (inflight_q < INF_MAX);
    assign her_descr_o = mem_q[rptr_q];

    assign push = her_valid_i && her_ready_o;
    assign pop  = her_valid_o && her_ready_i;
    assign fb   = feedback_valid_i;

    assign feedback_ready_o = 1'b1;
    assign occupancy_o      = occ_q;
    assign inflight_o       = inflight_q;
    assign eos_o            = eos_q;
    assign fb_underflow_o   = underflow_q;

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wptr_q] <= her_descr_i;
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        occ_d  = occ_q;
        if (push) begin
            wptr_d = wptr_q + PTR_ONE;
        end
        if (pop) begin
            rptr_d = rptr_q + PTR_ONE;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_ONE;
            2'b01:   occ_d = occ_q - OCC_ONE;
            default: occ_d = occ_q;
        endcase
    end

    // A completion with nothing outstanding is dropped and flagged instead of wrapping the counter.
    always_comb begin
        inflight_d  = inflight_q;
        underflow_d = underflow_q;
        case ({pop, fb})
            2'b10: inflight_d = inflight_q + INF_ONE;
            2'b01: begin
                if (inflight_q == '0) begin
                    underflow_d = 1'b1;
                end else begin
                    inflight_d = inflight_q - INF_ONE;
                end
            end
            default: inflight_d = inflight_q;
        endcase
    end

    always_comb begin
        eos_seen_d = eos_seen_q || eos_i;
        eos_d      = eos_q ||
                     (eos_seen_q && (occ_q == '0) && (inflight_q == '0) && !her_valid_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            occ_q       <= '0;
            inflight_q  <= '0;
            eos_seen_q  <= 1'b0;
            eos_q       <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            occ_q       <= occ_d;
            inflight_q  <= inflight_d;
            eos_seen_q  <= eos_seen_d;
            eos_q       <= eos_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_her_dispatch_buffer.sv
// Directed bench for her_dispatch_buffer: FIFO order, backpressure, in-flight cap,
// feedback corner cases, end-of-stream timing and mid-stream reset.
module tb_her_dispatch_buffer;

    localparam int DEPTH   = 8;
    localparam int MAX_INF = 4;
    localparam int DESCR_W = 64;
    localparam int OCC_W   = $clog2(DEPTH + 1);
    localparam int INF_W   = $clog2(MAX_INF + 1);

    logic               clk_i = 1'b0;
    logic               rst_i;
    logic               her_valid_i;
    logic               her_ready_o;
    logic [DESCR_W-1:0] her_descr_i;
    logic               her_valid_o;
    logic               her_ready_i;
    logic [DESCR_W-1:0] her_descr_o;
    logic               feedback_valid_i;
    logic               feedback_ready_o;
    logic               eos_i;
    logic               eos_o;
    logic [OCC_W-1:0]   occupancy_o;
    logic [INF_W-1:0]   inflight_o;
    logic               fb_underflow_o;

    int n_cmp = 0;
    int n_err = 0;

    her_dispatch_buffer #(
        .DEPTH        (DEPTH),
        .MAX_INFLIGHT (MAX_INF),
        .DESCR_W      (DESCR_W)
    ) dut (
        .clk_i            (clk_i),
        .rst_i            (rst_i),
        .her_valid_i      (her_valid_i),
        .her_ready_o      (her_ready_o),
        .her_descr_i      (her_descr_i),
        .her_valid_o      (her_valid_o),
        .her_ready_i      (her_ready_i),
        .her_descr_o      (her_descr_o),
        .feedback_valid_i (feedback_valid_i),
        .feedback_ready_o (feedback_ready_o),
        .eos_i            (eos_i),
        .eos_o            (eos_o),
        .occupancy_o      (occupancy_o),
        .inflight_o       (inflight_o),
        .fb_underflow_o   (fb_underflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Descriptor layout: {msgid[15:0], her_addr[31:0], marker[15:0]}
    function automatic logic [DESCR_W-1:0] mk(input int id, input logic [31:0] addr);
        logic [15:0] m;
        m = id[15:0];
        return {m, addr, 16'hBEEF};
    endfunction

    function automatic logic [DESCR_W-1:0] mkid(input int id);
        return mk(id, 32'h1C00_0000 + (id << 6));
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_i            = 1'b1;
        her_valid_i      = 1'b0;
        her_ready_i      = 1'b0;
        feedback_valid_i = 1'b0;
        eos_i            = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b0;
    endtask

    task automatic push_ids(input int first, input int count);
        for (int i = 0; i < count; i++) begin
            her_valid_i = 1'b1;
            her_descr_i = mkid(first + i);
            @(negedge clk_i);
        end
        her_valid_i = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int src;
        int exp_id;
        int pops;

        rst_i = 1'b1; her_valid_i = 1'b0; her_ready_i = 1'b0;
        her_descr_i = '0; feedback_valid_i = 1'b0; eos_i = 1'b0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        check("rst_occ",      occupancy_o,      0);
        check("rst_inflight", inflight_o,       0);
        check("rst_valid",    her_valid_o,      0);
        check("rst_ready",    her_ready_o,      1);
        check("rst_eos",      eos_o,            0);
        check("rst_underflow",fb_underflow_o,   0);
        check("fb_ready",     feedback_ready_o, 1);

        // Single packet
        her_valid_i = 1'b1;
        her_descr_i = mk(5, 32'h1C00_0000);
        @(negedge clk_i);
        her_valid_i = 1'b0;
        check("single_valid", her_valid_o, 1);
        check("single_descr", her_descr_o, mk(5, 32'h1C00_0000));
        check("single_occ",   occupancy_o, 1);
        her_ready_i = 1'b1;
        @(negedge clk_i);
        her_ready_i = 1'b0;
        check("single_inflight1", inflight_o,  1);
        check("single_occ0",      occupancy_o, 0);
        check("single_valid0",    her_valid_o, 0);
        feedback_valid_i = 1'b1;
        @(negedge clk_i);
        feedback_valid_i = 1'b0;
        check("single_inflight0", inflight_o,     0);
        check("single_underflow", fb_underflow_o, 0);

        // Fill / backpressure: 9 offered, 8 fit
        src = 0;
        her_ready_i = 1'b0;
        for (int c = 0; c < 10; c++) begin
            her_valid_i = (src < 9);
            her_descr_i = mkid(src);
            if (her_valid_i && her_ready_o) src++;
            @(negedge clk_i);
        end
        check("fill_accepted", src,         8);
        check("fill_occ",      occupancy_o, 8);
        check("fill_ready",    her_ready_o, 0);

        // Drain in order; feedback alongside each pop keeps inflight at 0
        exp_id = 0;
        her_ready_i = 1'b1;
        for (int c = 0; c < 14; c++) begin
            her_valid_i = (src < 9);
            her_descr_i = mkid(src);
            if (her_valid_i && her_ready_o) src++;
            feedback_valid_i = her_valid_o;
            if (her_valid_o) begin
                check("fifo_order", her_descr_o, mkid(exp_id));
                exp_id++;
            end
            @(negedge clk_i);
        end
        her_valid_i = 1'b0; her_ready_i = 1'b0; feedback_valid_i = 1'b0;
        check("drain_count",     exp_id,         9);
        check("drain_occ",       occupancy_o,    0);
        check("drain_inflight",  inflight_o,     0);
        check("drain_underflow", fb_underflow_o, 0);

        // In-flight cap of 4
        do_reset();
        push_ids(20, 6);
        check("cap_occ6", occupancy_o, 6);
        her_ready_i = 1'b1;
        pops = 0;
        for (int c = 0; c < 8; c++) begin
            if (her_valid_o) begin
                check("cap_order", her_descr_o, mkid(20 + pops));
                pops++;
            end
            @(negedge clk_i);
        end
        check("cap_pops",     pops,        4);
        check("cap_valid0",   her_valid_o, 0);
        check("cap_inflight", inflight_o,  4);
        check("cap_occ2",     occupancy_o, 2);
        feedback_valid_i = 1'b1;
        @(negedge clk_i);
        feedback_valid_i = 1'b0;
        check("cap_fb_inflight", inflight_o,  3);
        check("cap_fb_valid",    her_valid_o, 1);
        check("cap_fb_descr",    her_descr_o, mkid(24));
        @(negedge clk_i);
        her_ready_i = 1'b0;
        check("cap_5th_inflight", inflight_o,  4);
        check("cap_5th_occ",      occupancy_o, 1);
        check("cap_5th_valid",    her_valid_o, 0);

        // Simultaneous events
        do_reset();
        push_ids(30, 5);
        her_ready_i = 1'b1;
        repeat (2) @(negedge clk_i);
        check("sim_inflight2", inflight_o,  2);
        check("sim_occ3",      occupancy_o, 3);
        feedback_valid_i = 1'b1;
        @(negedge clk_i);
        feedback_valid_i = 1'b0;
        her_ready_i = 1'b0;
        check("pop_fb_inflight", inflight_o,  2);
        check("pop_fb_occ",      occupancy_o, 2);
        push_ids(35, 1);
        check("pre_pushpop_occ", occupancy_o, 3);
        her_valid_i = 1'b1;
        her_descr_i = mkid(36);
        her_ready_i = 1'b1;
        @(negedge clk_i);
        her_valid_i = 1'b0;
        her_ready_i = 1'b0;
        check("push_pop_occ",      occupancy_o, 3);
        check("push_pop_inflight", inflight_o,  3);
        check("push_pop_head",     her_descr_o, mkid(34));

        do_reset();
        feedback_valid_i = 1'b1;
        @(negedge clk_i);
        feedback_valid_i = 1'b0;
        check("underflow_set",      fb_underflow_o, 1);
        check("underflow_inflight", inflight_o,     0);
        @(negedge clk_i);
        check("underflow_sticky",   fb_underflow_o, 1);

        // End-of-stream after three completions at +10/+20/+30
        do_reset();
        check("eos_rst_underflow", fb_underflow_o, 0);
        her_ready_i = 1'b1;
        push_ids(40, 3);
        eos_i = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk_i);
            eos_i = 1'b0;
            if (c == 31) check("eos_inflight0", inflight_o, 0);
            check("eos_timing", eos_o, (c >= 32) ? 1 : 0);
            feedback_valid_i = (c == 10 || c == 20 || c == 30);
        end
        feedback_valid_i = 1'b0;
        her_ready_i = 1'b0;

        // Reset mid-stream
        do_reset();
        push_ids(50, 8);
        check("mid_full", occupancy_o, 8);
        her_ready_i = 1'b1;
        repeat (3) @(negedge clk_i);
        her_ready_i = 1'b0;
        check("mid_occ5",      occupancy_o, 5);
        check("mid_inflight3", inflight_o,  3);
        rst_i = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("mid_rst_occ",      occupancy_o, 0);
        check("mid_rst_inflight", inflight_o,  0);
        check("mid_rst_valid",    her_valid_o, 0);
        check("mid_rst_eos",      eos_o,       0);
        check("mid_rst_ready",    her_ready_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
